lock_ctrl_core: RTL and testbench

- Combinational/sequential core of the keypad lock.
- Routes the keypad "key valid" strobe to either the user-input (UI) or set-password (SP) capture path via a 1:2 demux.
- Compares the two captured 8-digit (32-bit, nibble-packed BCD) codes for equality.
- Counts unlock attempts in a single BCD digit; downstream alarm/unlock logic consumes `eq` and `attempt_count`.

---
 rtl/lock_pkg.sv | 19 +
 rtl/bcd_digit_counter.sv | 23 ++
 rtl/lock_ctrl_core.sv | 32 +++
 tb/tb_lock_ctrl_core.sv | 135 +++++++++++++
 4 files changed

// File: rtl/lock_pkg.sv
// rtl/lock_pkg.sv - shared constants, types and BCD helper for the keypad lock core
package lock_pkg;

    localparam int DIGIT_W = 4;
    localparam int DIGITS  = 8;

    typedef logic [DIGIT_W-1:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;

    // Any code at or above BCD_MAX (including the unreachable 10..15) rolls to zero.
    function automatic bcd_digit_t bcd_inc(input bcd_digit_t d);
        if (d >= BCD_MAX) begin
            return '0;
        end
        return d + 4'd1;
    endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// rtl/bcd_digit_counter.sv - single BCD digit counter with enable and wrap at BCD_MAX
module bcd_digit_counter
    import lock_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    output logic [3:0] count
);

    bcd_digit_t count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (en) begin
            count_q <= bcd_inc(count_q);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/lock_ctrl_core.sv
// rtl/lock_ctrl_core.sv - keypad strobe demux, code comparator and BCD attempt counter
module lock_ctrl_core
    import lock_pkg::*;
#(
    parameter int DATA_W = DIGITS * DIGIT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              din,
    input  logic              sel,
    output logic [1:0]        mode_out,
    input  logic [DATA_W-1:0] code_a,
    input  logic [DATA_W-1:0] code_b,
    output logic              eq,
    input  logic              attempt_stb,
    output logic [3:0]        attempt_count
);

    // Demux and comparator stay purely combinational so they work through reset.
    assign mode_out[0] = din & ~sel;
    assign mode_out[1] = din & sel;

    assign eq = (code_a == code_b);

    bcd_digit_counter u_attempt_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (attempt_stb),
        .count (attempt_count)
    );

endmodule

// File: tb/tb_lock_ctrl_core.sv
// tb/tb_lock_ctrl_core.sv - directed self-checking bench for lock_ctrl_core
module tb_lock_ctrl_core;

    logic        clk;
    logic        rst_n;
    logic        din;
    logic        sel;
    logic [1:0]  mode_out;
    logic [31:0] code_a;
    logic [31:0] code_b;
    logic        eq;
    logic        attempt_stb;
    logic [3:0]  attempt_count;

    int n_cmp = 0;
    int n_bad = 0;

    lock_ctrl_core #(.DATA_W(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .din           (din),
        .sel           (sel),
        .mode_out      (mode_out),
        .code_a        (code_a),
        .code_b        (code_b),
        .eq            (eq),
        .attempt_stb   (attempt_stb),
        .attempt_count (attempt_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic pulse();
        @(negedge clk);
        attempt_stb = 1'b1;
        @(negedge clk);
        attempt_stb = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("reset_clear", {28'd0, attempt_count}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        din = 1'b0;
        sel = 1'b0;
        code_a = '0;
        code_b = '0;
        attempt_stb = 1'b0;

        @(posedge clk);
        #1;
        check("reset_count", {28'd0, attempt_count}, 32'd0);

        din = 1'b1; sel = 1'b0; #1;
        check("demux_ui", {30'd0, mode_out}, 32'd1);
        sel = 1'b1; #1;
        check("demux_sp", {30'd0, mode_out}, 32'd2);
        din = 1'b0; sel = 1'b0; #1;
        check("demux_off_s0", {30'd0, mode_out}, 32'd0);
        sel = 1'b1; #1;
        check("demux_off_s1", {30'd0, mode_out}, 32'd0);

        code_a = 32'h21935488; code_b = 32'h21935488; #1;
        check("cmp_match", {31'd0, eq}, 32'd1);
        code_b = 32'h21935489; #1;
        check("cmp_bit0", {31'd0, eq}, 32'd0);
        code_b = 32'hA1935488; #1;
        check("cmp_msb_nib", {31'd0, eq}, 32'd0);
        code_b = 32'h21935488; #1;
        check("cmp_rematch", {31'd0, eq}, 32'd1);

        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            pulse();
            check($sformatf("seq_%0d", i), {28'd0, attempt_count}, (i == 10) ? 32'd0 : 32'(i));
        end
        pulse();
        pulse();
        pulse();
        repeat (5) @(negedge clk);
        check("hold_5clk", {28'd0, attempt_count}, 32'd3);

        do_reset();
        repeat (5) pulse();
        check("count5", {28'd0, attempt_count}, 32'd5);
        check("alarm_bits", {31'd0, attempt_count[0] & attempt_count[2]}, 32'd1);

        pulse();
        pulse();
        check("count7", {28'd0, attempt_count}, 32'd7);
        #2;
        rst_n = 1'b0;
        attempt_stb = 1'b1;
        #1;
        check("async_rst", {28'd0, attempt_count}, 32'd0);
        @(posedge clk);
        #1;
        check("rst_beats_stb", {28'd0, attempt_count}, 32'd0);
        @(negedge clk);
        attempt_stb = 1'b0;
        rst_n = 1'b1;
        pulse();
        check("post_rst_one", {28'd0, attempt_count}, 32'd1);

        do_reset();
        @(negedge clk);
        attempt_stb = 1'b1;
        repeat (3) @(negedge clk);
        attempt_stb = 1'b0;
        check("held_stb_3", {28'd0, attempt_count}, 32'd3);
        repeat (2) @(negedge clk);
        check("held_stb_hold", {28'd0, attempt_count}, 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
